multi_channel_timer: RTL and testbench

// - Bus-attached timer for the simple system; replaces the single-compare timer on the device bus.
// - Has one free-running 64-bit mtime counter with a programmable prescaler.
// - Has NumChannels compare channels, each configurable as one-shot or periodic (auto-reload).
// - Outputs a per-channel interrupt vector plus an aggregated irq routed to the core's irq_timer_i.

---
 rtl/multi_channel_timer_pkg.sv | 36 +++
 rtl/multi_channel_timer_if.sv | 25 ++
 rtl/multi_channel_timer_channel.sv | 77 +++++++
 rtl/multi_channel_timer.sv | 183 ++++++++++++++++++
 tb/tb_multi_channel_timer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_channel_timer_pkg.sv
// Shared definitions for the multi-channel timer: register map, channel config
// layout and the byte-enable merge helper used by every writable register.
package multi_channel_timer_pkg;

    localparam int MaxChannels = 8;

    localparam logic [9:0] OffMtimeLo  = 10'h000;
    localparam logic [9:0] OffMtimeHi  = 10'h004;
    localparam logic [9:0] OffPrescale = 10'h008;
    localparam logic [9:0] OffCtrl     = 10'h00C;
    localparam logic [9:0] OffStatus   = 10'h010;
    localparam logic [9:0] OffIrqEn    = 10'h014;
    localparam logic [9:0] OffChanBase = 10'h100;

    localparam logic [1:0] ChCmpLo  = 2'd0;
    localparam logic [1:0] ChCmpHi  = 2'd1;
    localparam logic [1:0] ChCfg    = 2'd2;
    localparam logic [1:0] ChPeriod = 2'd3;

    typedef struct packed {
        logic periodic;
        logic en;
    } chan_cfg_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res[7:0]   = be[0] ? new_val[7:0]   : old_val[7:0];
        res[15:8]  = be[1] ? new_val[15:8]  : old_val[15:8];
        res[23:16] = be[2] ? new_val[23:16] : old_val[23:16];
        res[31:24] = be[3] ? new_val[31:24] : old_val[31:24];
        return res;
    endfunction

endpackage

// File: rtl/multi_channel_timer_if.sv
// Device-bus port bundle of the timer: request side driven by the core,
// single-cycle response side driven by the timer.
interface multi_channel_timer_if #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    logic                    req_i;
    logic                    we_i;
    logic [3:0]              be_i;
    logic [AddressWidth-1:0] addr_i;
    logic [DataWidth-1:0]    wdata_i;
    logic                    rvalid_o;
    logic [DataWidth-1:0]    rdata_o;
    logic                    err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/multi_channel_timer_channel.sv
// One compare channel: 64-bit compare value, reload period and config, with the
// mtime comparator and the one-shot disable / periodic auto-advance.
module timer_channel
    import multi_channel_timer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] mtime,
    input  logic [3:0]  wr_sel,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [63:0] cmp,
    output logic [31:0] period,
    output chan_cfg_t   cfg,
    output logic        fire_o
);

    logic [63:0] cmp_r, cmp_d, adv_cmp_s;
    logic [31:0] period_r, period_d;
    chan_cfg_t   cfg_r, cfg_d, adv_cfg_s;
    logic        fire_s;

    // Compare, hardware update, then software writes which take priority.
    always_comb begin
        fire_s    = cfg_r.en & (mtime >= cmp_r);
        adv_cmp_s = cmp_r;
        adv_cfg_s = cfg_r;
        cmp_d     = cmp_r;
        cfg_d     = cfg_r;
        period_d  = period_r;
        if (fire_s && cfg_r.periodic) begin
            adv_cmp_s = cmp_r + {32'd0, period_r};
        end else if (fire_s) begin
            adv_cfg_s.en = 1'b0;
        end else begin
            adv_cmp_s = cmp_r;
        end
        if (wr_sel[ChCmpLo]) begin
            cmp_d = {cmp_r[63:32], be_merge(cmp_r[31:0], wdata, be)};
        end else if (wr_sel[ChCmpHi]) begin
            cmp_d = {be_merge(cmp_r[63:32], wdata, be), cmp_r[31:0]};
        end else begin
            cmp_d = adv_cmp_s;
        end
        if (wr_sel[ChCfg] && be[0]) begin
            cfg_d = chan_cfg_t'(wdata[1:0]);
        end else if (wr_sel[ChCfg]) begin
            cfg_d = cfg_r;
        end else begin
            cfg_d = adv_cfg_s;
        end
        if (wr_sel[ChPeriod]) begin
            period_d = be_merge(period_r, wdata, be);
        end else begin
            period_d = period_r;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmp_r    <= 64'd0;
            period_r <= 32'd0;
            cfg_r    <= 2'b00;
        end else begin
            cmp_r    <= cmp_d;
            period_r <= period_d;
            cfg_r    <= cfg_d;
        end
    end

    assign cmp    = cmp_r;
    assign period = period_r;
    assign cfg    = cfg_r;
    assign fire_o = fire_s;

endmodule

// File: rtl/multi_channel_timer.sv
// Bus-attached timer: prescaled 64-bit mtime, coherent high-word shadow,
// sticky STATUS/IRQ_EN and NumChannels compare channels with registered irqs.
module multi_channel_timer
    import multi_channel_timer_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int NumChannels   = 4,
    parameter int PrescaleWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    multi_channel_timer_if.slave   bus,
    output logic [NumChannels-1:0] irq_vec_o,
    output logic                   irq_o
);

    logic [63:0]              mtime_r, mtime_d;
    logic [PrescaleWidth-1:0] prescale_r, prescale_d, pcnt_r, pcnt_d;
    logic                     ctrl_en_r, ctrl_en_d;
    logic [31:0]              shadow_r, shadow_d;
    logic [NumChannels-1:0]   status_r, status_d, irq_en_r, irq_en_d, irq_vec_r, w1c_s;
    logic [NumChannels-1:0]   fire_vec_s;
    logic                     irq_r, rvalid_r, err_r, err_d;
    logic [DataWidth-1:0]     rdata_r, rdata_d;
    logic [31:0]              rd_mux_s, pre_merge_s;
    logic [9:0]               word_off_s;
    logic [3:0]               ch_idx_s;
    logic [1:0]               ch_reg_s;
    logic                     wr_s, rd_s, is_chan_s, is_top_s, valid_s, tick_s;
    logic                     wr_mlo_s, wr_mhi_s, wr_pre_s, wr_ctrl_s, wr_stat_s, wr_ien_s;
    logic                     unused_addr_s;

    logic [63:0] ch_cmp_s    [MaxChannels];
    logic [31:0] ch_period_s [MaxChannels];
    chan_cfg_t   ch_cfg_s    [MaxChannels];

    assign unused_addr_s = ^{bus.addr_i[AddressWidth-1:10], bus.addr_i[1:0]};

    // Address decode and per-register write strobes.
    always_comb begin
        word_off_s = {bus.addr_i[9:2], 2'b00};
        ch_idx_s   = bus.addr_i[7:4];
        ch_reg_s   = bus.addr_i[3:2];
        wr_s       = bus.req_i & bus.we_i;
        rd_s       = bus.req_i & ~bus.we_i;
        is_chan_s  = (word_off_s[9:8] == OffChanBase[9:8]) && (32'(ch_idx_s) < NumChannels);
        case (word_off_s)
            OffMtimeLo, OffMtimeHi, OffPrescale,
            OffCtrl, OffStatus, OffIrqEn: is_top_s = 1'b1;
            default:                      is_top_s = 1'b0;
        endcase
        valid_s   = is_top_s | is_chan_s;
        wr_mlo_s  = wr_s && (word_off_s == OffMtimeLo);
        wr_mhi_s  = wr_s && (word_off_s == OffMtimeHi);
        wr_pre_s  = wr_s && (word_off_s == OffPrescale);
        wr_ctrl_s = wr_s && (word_off_s == OffCtrl);
        wr_stat_s = wr_s && (word_off_s == OffStatus);
        wr_ien_s  = wr_s && (word_off_s == OffIrqEn);
    end

    for (genvar c = 0; c < MaxChannels; c++) begin : g_ch
        if (c < NumChannels) begin : g_on
            logic [3:0] wr_sel_s;
            assign wr_sel_s = (wr_s && is_chan_s && (ch_idx_s == 4'(c)))
                            ? (4'b0001 << ch_reg_s) : 4'b0000;
            timer_channel u_chan (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .mtime  (mtime_r),
                .wr_sel (wr_sel_s),
                .wdata  (bus.wdata_i),
                .be     (bus.be_i),
                .cmp    (ch_cmp_s[c]),
                .period (ch_period_s[c]),
                .cfg    (ch_cfg_s[c]),
                .fire_o (fire_vec_s[c])
            );
        end else begin : g_off
            assign ch_cmp_s[c]    = 64'd0;
            assign ch_period_s[c] = 32'd0;
            assign ch_cfg_s[c]    = 2'b00;
        end
    end

    // Prescaler, mtime, control and status next-state; SW writes beat the tick.
    always_comb begin
        tick_s      = ctrl_en_r & (pcnt_r == {PrescaleWidth{1'b0}});
        pre_merge_s = be_merge(32'(prescale_r), bus.wdata_i, bus.be_i);
        prescale_d  = wr_pre_s ? pre_merge_s[PrescaleWidth-1:0] : prescale_r;
        if (wr_pre_s) begin
            pcnt_d = pre_merge_s[PrescaleWidth-1:0];
        end else if (tick_s) begin
            pcnt_d = prescale_r;
        end else if (ctrl_en_r) begin
            pcnt_d = pcnt_r - {{(PrescaleWidth-1){1'b0}}, 1'b1};
        end else begin
            pcnt_d = pcnt_r;
        end
        if (wr_mlo_s) begin
            mtime_d = {mtime_r[63:32], be_merge(mtime_r[31:0], bus.wdata_i, bus.be_i)};
        end else if (wr_mhi_s) begin
            mtime_d = {be_merge(mtime_r[63:32], bus.wdata_i, bus.be_i), mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_d = mtime_r + 64'd1;
        end else begin
            mtime_d = mtime_r;
        end
        shadow_d  = (rd_s && (word_off_s == OffMtimeLo)) ? mtime_r[63:32] : shadow_r;
        ctrl_en_d = (wr_ctrl_s && bus.be_i[0]) ? bus.wdata_i[0] : ctrl_en_r;
        irq_en_d  = (wr_ien_s && bus.be_i[0]) ? bus.wdata_i[NumChannels-1:0] : irq_en_r;
        w1c_s     = (wr_stat_s && bus.be_i[0]) ? bus.wdata_i[NumChannels-1:0]
                                               : {NumChannels{1'b0}};
        // A hardware fire in the same cycle overrides the software clear.
        status_d  = (status_r & ~w1c_s) | fire_vec_s;
    end

    // Read data multiplexer.
    always_comb begin
        rd_mux_s = 32'd0;
        case (word_off_s)
            OffMtimeLo:  rd_mux_s = mtime_r[31:0];
            OffMtimeHi:  rd_mux_s = shadow_r;
            OffPrescale: rd_mux_s = 32'(prescale_r);
            OffCtrl:     rd_mux_s = {31'd0, ctrl_en_r};
            OffStatus:   rd_mux_s = 32'(status_r);
            OffIrqEn:    rd_mux_s = 32'(irq_en_r);
            default: begin
                if (is_chan_s) begin
                    case (ch_reg_s)
                        ChCmpLo:  rd_mux_s = ch_cmp_s[ch_idx_s[2:0]][31:0];
                        ChCmpHi:  rd_mux_s = ch_cmp_s[ch_idx_s[2:0]][63:32];
                        ChCfg:    rd_mux_s = {30'd0, ch_cfg_s[ch_idx_s[2:0]]};
                        ChPeriod: rd_mux_s = ch_period_s[ch_idx_s[2:0]];
                        default:  rd_mux_s = 32'd0;
                    endcase
                end else begin
                    rd_mux_s = 32'd0;
                end
            end
        endcase
        rdata_d = (rd_s && valid_s) ? rd_mux_s : {DataWidth{1'b0}};
        err_d   = bus.req_i & ~valid_s;
    end

    // Timer state, bus response and irq output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime_r    <= 64'd0;
            prescale_r <= {PrescaleWidth{1'b0}};
            pcnt_r     <= {PrescaleWidth{1'b0}};
            ctrl_en_r  <= 1'b0;
            shadow_r   <= 32'd0;
            status_r   <= {NumChannels{1'b0}};
            irq_en_r   <= {NumChannels{1'b0}};
            irq_vec_r  <= {NumChannels{1'b0}};
            irq_r      <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= {DataWidth{1'b0}};
            err_r      <= 1'b0;
        end else begin
            mtime_r    <= mtime_d;
            prescale_r <= prescale_d;
            pcnt_r     <= pcnt_d;
            ctrl_en_r  <= ctrl_en_d;
            shadow_r   <= shadow_d;
            status_r   <= status_d;
            irq_en_r   <= irq_en_d;
            irq_vec_r  <= status_d & irq_en_d;
            irq_r      <= |(status_d & irq_en_d);
            rvalid_r   <= bus.req_i;
            rdata_r    <= rdata_d;
            err_r      <= err_d;
        end
    end

    assign bus.rvalid_o = rvalid_r;
    assign bus.rdata_o  = rdata_r;
    assign bus.err_o    = err_r;
    assign irq_vec_o    = irq_vec_r;
    assign irq_o        = irq_r;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench: bus tasks queue expected responses, a negedge monitor pops
// and compares each response; irq/reset behaviour is checked inline.
module tb_multi_channel_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] irq_vec;
    logic       irq;

    always #5 clk = ~clk;

    multi_channel_timer_if #(.DataWidth(32), .AddressWidth(32)) bus ();

    multi_channel_timer #(.NumChannels(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .irq_vec_o (irq_vec),
        .irq_o     (irq)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rvalid_o === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_rsp: got rdata=%h err=%b, expected no response",
                         bus.rdata_o, bus.err_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rdata_o !== mon_e.data || bus.err_o !== mon_e.err) begin
                    n_bad++;
                    $display("FAIL %s: got rdata=%h err=%b, expected rdata=%h err=%b",
                             mon_e.name, bus.rdata_o, bus.err_o, mon_e.data, mon_e.err);
                end
            end
        end
    end

    task automatic bus_wr(input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] be = 4'hF, input logic err = 1'b0);
        exp_t e;
        e.data = 32'd0;
        e.err  = err;
        e.name = $sformatf("wr_%03h", a);
        exp_q.push_back(e);
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.be_i    = be;
        bus.addr_i  = {22'd0, a};
        bus.wdata_i = d;
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
        bus.we_i  = 1'b0;
    endtask

    task automatic bus_rd(input string name, input logic [9:0] a,
                          input logic [31:0] d, input logic err = 1'b0);
        exp_t e;
        e.data = d;
        e.err  = err;
        e.name = name;
        exp_q.push_back(e);
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.be_i   = 4'hF;
        bus.addr_i = {22'd0, a};
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.be_i    = 4'h0;
        bus.addr_i  = 32'd0;
        bus.wdata_i = 32'd0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
        check("rst_irq_vec", 32'(irq_vec), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        bus_rd("rst_mtime_lo", 10'h000, 32'd0);
        bus_rd("rst_prescale", 10'h008, 32'd0);
        bus_rd("rst_ctrl", 10'h00C, 32'd0);
        bus_rd("rst_status", 10'h010, 32'd0);

        // Prescale 3: one tick per 4 cycles, 40 cycles -> 10.
        bus_wr(10'h008, 32'd3);
        bus_wr(10'h00C, 32'd1);
        idle(39);
        bus_wr(10'h00C, 32'd0);
        bus_rd("mtime_lo_10", 10'h000, 32'd10);
        bus_wr(10'h004, 32'd5);
        bus_rd("mtime_hi_shadow", 10'h004, 32'd0);
        bus_rd("mtime_lo_again", 10'h000, 32'd10);
        bus_rd("mtime_hi_new", 10'h004, 32'd5);

        // Error responses.
        bus_rd("err_0fc", 10'h0FC, 32'd0, 1'b1);
        bus_rd("err_ch4", 10'h140, 32'd0, 1'b1);
        bus_wr(10'h018, 32'hDEAD_BEEF, 4'hF, 1'b1);
        bus_rd("err_200", 10'h200, 32'd0, 1'b1);

        // Byte enables.
        bus_wr(10'h008, 32'h0000_AAAA);
        bus_wr(10'h008, 32'h1234_5678, 4'b0001);
        bus_rd("prescale_be", 10'h008, 32'h0000_AA78);
        bus_wr(10'h008, 32'd0);

        // Channel 0 one-shot at 100, counting from 90 every cycle.
        bus_wr(10'h004, 32'd0);
        bus_wr(10'h000, 32'd90);
        bus_wr(10'h100, 32'd100);
        bus_wr(10'h104, 32'd0);
        bus_wr(10'h108, 32'd1);
        bus_wr(10'h014, 32'd1);
        bus_wr(10'h00C, 32'd1);
        idle(10);
        check("irq_vec_before_fire", 32'(irq_vec), 32'd0);
        idle(1);
        check("irq_vec_after_fire", 32'(irq_vec), 32'd1);
        check("irq_after_fire", 32'(irq), 32'd1);
        bus_wr(10'h00C, 32'd0);
        bus_rd("cfg0_oneshot_cleared", 10'h108, 32'd0);
        bus_rd("status_ch0", 10'h010, 32'd1);
        bus_rd("mtime_lo_102", 10'h000, 32'd102);
        bus_wr(10'h010, 32'd1);
        check("irq_vec_w1c", 32'(irq_vec), 32'd0);
        bus_rd("status_cleared", 10'h010, 32'd0);

        // Channel 1 periodic: cmp 50, period 20.
        bus_wr(10'h000, 32'd0);
        bus_wr(10'h110, 32'd50);
        bus_wr(10'h11C, 32'd20);
        bus_wr(10'h118, 32'd3);
        bus_wr(10'h000, 32'd50);
        idle(1);
        bus_rd("ch1_cmp_70", 10'h110, 32'd70);
        bus_wr(10'h000, 32'd70);
        idle(1);
        bus_rd("ch1_cmp_90", 10'h110, 32'd90);
        bus_wr(10'h000, 32'd90);
        idle(1);
        bus_rd("ch1_cmp_110", 10'h110, 32'd110);
        bus_rd("status_ch1", 10'h010, 32'd2);
        bus_wr(10'h000, 32'd200);
        idle(6);
        bus_rd("ch1_catch_up", 10'h110, 32'd210);
        bus_rd("ch1_cmp_hi", 10'h114, 32'd0);

        // Channel 2 periodic with period 0 fires every cycle; W1C collides.
        bus_wr(10'h118, 32'd0);
        bus_wr(10'h010, 32'hF);
        bus_rd("status_all_clear", 10'h010, 32'd0);
        bus_wr(10'h128, 32'd3);
        bus_wr(10'h010, 32'd4);
        bus_rd("status_ch2_kept", 10'h010, 32'd4);
        bus_rd("ch2_cmp_held", 10'h120, 32'd0);
        bus_wr(10'h128, 32'd0);
        bus_wr(10'h010, 32'd4);
        bus_rd("status_ch2_clear", 10'h010, 32'd0);

        // Wrap: channel 3 at 2^64-1, three ticks from 2^64-2.
        bus_wr(10'h130, 32'hFFFF_FFFF);
        bus_wr(10'h134, 32'hFFFF_FFFF);
        bus_wr(10'h000, 32'hFFFF_FFFE);
        bus_wr(10'h004, 32'hFFFF_FFFF);
        bus_wr(10'h138, 32'd1);
        bus_wr(10'h00C, 32'd1);
        idle(2);
        bus_wr(10'h00C, 32'd0);
        bus_rd("wrap_lo", 10'h000, 32'd1);
        bus_rd("wrap_hi", 10'h004, 32'd0);
        bus_rd("wrap_status", 10'h010, 32'd8);
        bus_rd("wrap_cfg3", 10'h138, 32'd0);
        bus_wr(10'h010, 32'd8);
        idle(3);
        bus_rd("wrap_no_refire", 10'h010, 32'd0);

        // Reset while counting with irq high and a response in flight.
        bus_wr(10'h100, 32'd0);
        bus_wr(10'h104, 32'd0);
        bus_wr(10'h108, 32'd1);
        bus_wr(10'h00C, 32'd1);
        check("irq_before_reset", 32'(irq), 32'd1);
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.addr_i = 32'd0;
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
        check("rvalid_pending", 32'(bus.rvalid_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rvalid", 32'(bus.rvalid_o), 32'd0);
        check("async_rdata", bus.rdata_o, 32'd0);
        check("async_irq", 32'(irq), 32'd0);
        check("async_irq_vec", 32'(irq_vec), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus_rd("post_rst_mtime", 10'h000, 32'd0);
        bus_rd("post_rst_ctrl", 10'h00C, 32'd0);
        idle(3);
        bus_rd("post_rst_mtime_idle", 10'h000, 32'd0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_timeout: got %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
